// File: rtl/pulse_merger_pkg.sv
// Shared types and helpers for the pulse merger: FSM state encoding and the
// saturating up/down step used by the per-channel pending counters.
package pulse_merger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Saturating add of (+inc -dec) to cnt, clamped to [0, max_val].
  // inc and dec together cancel, so a saturated count with a simultaneous
  // grant and new pulse stays at max_val.
  function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                          input logic        inc,
                                          input logic        dec,
                                          input logic [31:0] max_val);
    logic [31:0] res;
    res = cnt;
    if (inc && !dec) begin
      if (cnt < max_val) res = cnt + 32'd1;
    end else if (dec && !inc) begin
      if (cnt != 32'd0) res = cnt - 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pulse_merger_round_robin_arbiter.sv
// Combinational round-robin arbiter. Searches from last+1 (mod CHANNELS)
// upward and grants the first requesting channel.
// Handshake: grant_valid is high exactly when enable is high and at least one
// req bit is set; grant is then one-hot and grant_idx names that bit. With
// grant_valid low, grant is all zero and grant_idx is zero.
module round_robin_arbiter
  import pulse_merger_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int INDEX_WIDTH = 2
) (
  input  logic [CHANNELS-1:0]    req,
  input  logic [INDEX_WIDTH-1:0] last,
  input  logic                   enable,
  output logic [CHANNELS-1:0]    grant,
  output logic [INDEX_WIDTH-1:0] grant_idx,
  output logic                   grant_valid
);

  // Rotating priority search starting one past the previous winner.
  always_comb begin : pick
    logic [INDEX_WIDTH-1:0] cand;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int off = 1; off <= CHANNELS; off++) begin
      cand = INDEX_WIDTH'((int'(last) + off) % CHANNELS);
      if (enable && !grant_valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_merger.sv
// Merges per-channel pulse streams onto one output pulse line. Each channel
// queues pulses in a saturating pending counter; a round-robin scheduler
// drains them as one-cycle pulses separated by at least MIN_GAP low cycles,
// tagging each pulse with its source channel.
module pulse_merger
  import pulse_merger_pkg::*;
#(
  parameter int CHANNELS            = 4,
  parameter int PULSE_COUNTER_WIDTH = 3,
  parameter int MIN_GAP             = 1,
  localparam int INDEX_WIDTH        = $clog2(CHANNELS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CHANNELS-1:0]    pulse_in,
  input  logic                   clear,
  output logic                   pulse_out,
  output logic [INDEX_WIDTH-1:0] pulse_index,
  output logic [CHANNELS-1:0]    busy,
  output logic                   pending
);

  localparam int W     = PULSE_COUNTER_WIDTH;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [W-1:0]           CNT_MAX   = '1;
  localparam logic [GAP_W-1:0]       GAP_LOAD  = GAP_W'(MIN_GAP - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_INIT = INDEX_WIDTH'(CHANNELS - 1);

  // Registered state
  state_t                 state_q, state_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [INDEX_WIDTH-1:0] last_q, last_d;
  logic                   pulse_out_q, pulse_out_d;
  logic [INDEX_WIDTH-1:0] pulse_index_q, pulse_index_d;
  logic [W-1:0]           count_q [CHANNELS];
  logic [W-1:0]           count_d [CHANNELS];

  // Scheduler signals
  logic [CHANNELS-1:0]    req;
  logic [CHANNELS-1:0]    grant;
  logic [INDEX_WIDTH-1:0] grant_idx;
  logic                   grant_valid;
  logic                   grant_window;
  logic                   grant_enable;

  // A grant may only be issued from IDLE or on the final gap cycle, and
  // never in a cycle where clear is flushing the counters.
  assign grant_window = (state_q == ST_IDLE) ||
                        ((state_q == ST_GAP) && (gap_q == '0));
  assign grant_enable = grant_window && !clear;

  // Requests include this cycle's input so a fresh pulse can win immediately.
  always_comb begin
    req = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      req[i] = (count_q[i] != '0) || pulse_in[i];
    end
  end

  round_robin_arbiter #(
    .CHANNELS    (CHANNELS),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_arb (
    .req         (req),
    .last        (last_q),
    .enable      (grant_enable),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Next pending counts: clear wins; otherwise +pulse -grant with saturation.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      count_d[i] = '0;
      if (!clear) begin
        count_d[i] = W'(sat_add(32'(count_q[i]), pulse_in[i], grant[i],
                                32'(CNT_MAX)));
      end
    end
  end

  // Round-robin pointer follows the most recent winner.
  always_comb begin
    last_d = last_q;
    if (grant_valid) last_d = grant_idx;
  end

  // FSM next state: IDLE -> PULSE on grant, PULSE -> GAP, GAP counts down and
  // on its last cycle either re-grants into PULSE or falls back to IDLE.
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    pulse_out_d   = 1'b0;
    pulse_index_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) state_d = ST_PULSE;
      end
      ST_PULSE: begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = grant_valid ? ST_PULSE : ST_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A grant only happens where the FSM moves into PULSE, so the registered
    // pulse outputs track the PULSE state exactly.
    if (grant_valid) begin
      pulse_out_d   = 1'b1;
      pulse_index_d = grant_idx;
    end
  end

  // FSM state, gap counter and registered pulse outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gap_q         <= '0;
      pulse_out_q   <= 1'b0;
      pulse_index_q <= '0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      pulse_out_q   <= pulse_out_d;
      pulse_index_q <= pulse_index_d;
    end
  end

  // Pending counters and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= LAST_INIT;
      for (int i = 0; i < CHANNELS; i++) count_q[i] <= '0;
    end else begin
      last_q <= last_d;
      for (int i = 0; i < CHANNELS; i++) count_q[i] <= count_d[i];
    end
  end

  // Status: busy flags saturated counters, pending flags any outstanding work.
  always_comb begin
    busy    = '0;
    pending = pulse_out_q;
    for (int i = 0; i < CHANNELS; i++) begin
      busy[i] = (count_q[i] == CNT_MAX);
      if (count_q[i] != '0) pending = 1'b1;
    end
  end

  assign pulse_out   = pulse_out_q;
  assign pulse_index = pulse_index_q;

endmodule

// File: tb/tb_pulse_merger.sv
// Testbench for pulse_merger (CHANNELS=4, W=3, MIN_GAP=1): a table of
// per-cycle vectors with hand-computed outputs, a held-input saturation
// sequence, and a random run checked against a round-robin model with an
// expected-index queue.
module tb_pulse_merger;

  localparam int CH      = 4;
  localparam int CNT_MAX = 7;
  localparam int GAP     = 1;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       reset;
  logic       clear;
  logic [3:0] pulse_in;
  logic       pulse_out;
  logic [1:0] pulse_index;
  logic [3:0] busy;
  logic       pending;

  always #5 clock = ~clock;

  pulse_merger #(
    .CHANNELS            (4),
    .PULSE_COUNTER_WIDTH (3),
    .MIN_GAP             (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .clear       (clear),
    .pulse_out   (pulse_out),
    .pulse_index (pulse_index),
    .busy        (busy),
    .pending     (pending)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic       obs_po;
  logic [1:0] obs_idx;
  logic [3:0] obs_busy;
  logic       obs_pend;
  logic       prev_po = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture outputs mid-cycle; a pulse must always be followed by a low cycle.
  task automatic sample();
    @(negedge clock);
    obs_po   = pulse_out;
    obs_idx  = pulse_index;
    obs_busy = busy;
    obs_pend = pending;
    if (prev_po) check("gap", 32'(obs_po), 32'd0);
    prev_po = obs_po;
  endtask

  // ---------------- reference model / scoreboard ----------------
  int         m_cnt [CH];
  int         m_last = CH - 1;
  int         m_cool = 0;
  logic       m_po = 1'b0;
  int         m_accepted = 0;
  int         dut_pulses = 0;
  logic [1:0] exp_q[$];

  initial for (int i = 0; i < CH; i++) m_cnt[i] = 0;

  task automatic model_step(input logic r, input logic c, input logic [3:0] p);
    int   g;
    int   ch;
    logic gv;
    g  = 0;
    gv = 1'b0;
    if (r) begin
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
      m_last     = CH - 1;
      m_cool     = 0;
      m_po       = 1'b0;
      m_accepted = 0;
      dut_pulses = 0;
      exp_q.delete();
    end else begin
      if (!c && m_cool == 0) begin
        for (int off = 1; off <= CH; off++) begin
          ch = (m_last + off) % CH;
          if (!gv && (m_cnt[ch] > 0 || p[ch])) begin
            g  = ch;
            gv = 1'b1;
          end
        end
      end
      for (int i = 0; i < CH; i++) begin
        if (c) begin
          m_cnt[i] = 0;
        end else begin
          if (p[i]) begin
            if (m_cnt[i] == CNT_MAX && !(gv && g == i)) begin
              // dropped: saturated and not granted
            end else begin
              m_accepted++;
              if (!(gv && g == i)) m_cnt[i]++;
            end
          end
          if (!p[i] && gv && g == i && m_cnt[i] > 0) m_cnt[i]--;
        end
      end
      m_po = gv;
      if (gv) begin
        exp_q.push_back(2'(g));
        m_last = g;
        m_cool = GAP;
      end else if (m_cool > 0) begin
        m_cool--;
      end
    end
  endtask

  // One clock of model-checked operation.
  task automatic run_cycle(input logic r, input logic c, input logic [3:0] p);
    logic [3:0] eb;
    logic       ep;
    reset    = r;
    clear    = c;
    pulse_in = p;
    sample();
    check("m_pulse_out", 32'(obs_po), 32'(m_po));
    if (obs_po) begin
      dut_pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL m_index: pulse index %0d with empty expected queue", obs_idx);
      end else begin
        check("m_index", 32'(obs_idx), 32'(exp_q.pop_front()));
      end
    end else begin
      check("m_index_idle", 32'(obs_idx), 32'd0);
    end
    eb = '0;
    ep = m_po;
    for (int i = 0; i < CH; i++) begin
      eb[i] = (m_cnt[i] == CNT_MAX);
      if (m_cnt[i] > 0) ep = 1'b1;
    end
    check("m_busy", 32'(obs_busy), 32'(eb));
    check("m_pending", 32'(obs_pend), 32'(ep));
    model_step(r, c, p);
    @(posedge clock);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic       clr;
    logic [3:0] pin;
    logic       po;
    logic [1:0] idx;
    logic [3:0] bsy;
    logic       pend;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic c, input logic [3:0] p,
                     input logic po, input logic [1:0] idx, input logic pend);
    vq.push_back('{rst: r, clr: c, pin: p, po: po, idx: idx, bsy: 4'b0000, pend: pend});
  endtask

  initial begin
    logic [3:0] p;

    // Single pulse on channel 2: pulse next cycle with index 2, then idle.
    add(0, 0, 4'b0000, 0, 0, 0);  // reset state
    add(0, 0, 4'b0100, 0, 0, 0);
    add(0, 0, 4'b0000, 1, 2, 1);
    add(0, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 4'b0000, 0, 0, 0);
    // All four at once after reset: indices 0,1,2,3 every other cycle.
    add(1, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 4'b1111, 0, 0, 0);
    add(0, 0, 4'b0000, 1, 0, 1);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 2, 1);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 3, 1);
    add(0, 0, 4'b0000, 0, 0, 0);
    // Channel 1 held four cycles: four pulses, index 1, spaced by two.
    add(0, 0, 4'b0010, 0, 0, 0);
    add(0, 0, 4'b0010, 1, 1, 1);
    add(0, 0, 4'b0010, 0, 0, 1);
    add(0, 0, 4'b0010, 1, 1, 1);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 1, 1);
    add(0, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 4'b0000, 0, 0, 0);
    // Channels 0 and 3 loaded, clear during a pulse (with a new pulse on 2).
    add(1, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 4'b1001, 0, 0, 0);
    add(0, 0, 4'b1001, 1, 0, 1);
    add(0, 0, 4'b1001, 0, 0, 1);
    add(0, 0, 4'b1001, 1, 3, 1);
    add(0, 0, 4'b1001, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 0, 1);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(0, 1, 4'b0100, 1, 3, 1);
    add(0, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 4'b0000, 0, 0, 0);
    // Clear in IDLE blocks the grant and discards the arriving pulse.
    add(0, 1, 4'b0001, 0, 0, 0);
    add(0, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 4'b0000, 0, 0, 0);
    // Reset during a pulse ends it and restores the pointer to channel 3.
    add(0, 0, 4'b0100, 0, 0, 0);
    add(1, 0, 4'b1000, 1, 2, 1);
    add(0, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 4'b1001, 0, 0, 0);
    add(0, 0, 4'b0000, 1, 0, 1);
    add(0, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 4'b0000, 1, 3, 1);
    add(0, 0, 4'b0000, 0, 0, 0);

    // Power-on reset.
    reset    = 1'b1;
    clear    = 1'b0;
    pulse_in = '0;
    repeat (2) @(posedge clock);
    #1;

    foreach (vq[i]) begin
      reset    = vq[i].rst;
      clear    = vq[i].clr;
      pulse_in = vq[i].pin;
      sample();
      check($sformatf("vec%0d {po,idx,busy,pend}", i),
            32'({obs_po, obs_idx, obs_busy, obs_pend}),
            32'({vq[i].po, vq[i].idx, vq[i].bsy, vq[i].pend}));
      @(posedge clock);
      #1;
    end

    // Channel 0 held for 20 cycles: saturates at 7, 3 pulses dropped,
    // 17 pulses total, busy falls once draining starts.
    run_cycle(1, 0, 4'b0000);
    for (int c = 0; c < 50; c++) begin
      run_cycle(0, 0, (c < 20) ? 4'b0001 : 4'b0000);
      if (c == 13) check("sat_busy_c13", 32'(obs_busy[0]), 32'd0);
      if (c == 14) check("sat_busy_c14", 32'(obs_busy[0]), 32'd1);
      if (c == 20) check("sat_busy_c20", 32'(obs_busy[0]), 32'd1);
      if (c == 21) check("sat_busy_c21", 32'(obs_busy[0]), 32'd0);
    end
    check("sat_total", 32'(dut_pulses), 32'd17);
    check("sat_total_vs_model", 32'(dut_pulses), 32'(m_accepted));
    check("sat_idle", 32'({obs_busy, obs_pend}), 32'd0);

    // Random traffic with a reset in the middle.
    run_cycle(1, 0, 4'b0000);
    for (int t = 0; t < 200; t++) begin
      for (int b = 0; b < CH; b++) p[b] = ($urandom_range(0, 9) < 3);
      run_cycle((t == 100), 0, p);
      if (t == 101) begin
        check("rand_after_reset", 32'({obs_po, obs_idx, obs_busy, obs_pend}), 32'd0);
      end
    end
    for (int t = 0; t < 80; t++) run_cycle(0, 0, 4'b0000);
    check("rand_queue_drained", 32'(exp_q.size()), 32'd0);
    check("rand_total_vs_model", 32'(dut_pulses), 32'(m_accepted));
    check("rand_idle", 32'({obs_busy, obs_pend}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
